// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - shares one device memory port between several bus hosts
// Grants one host per cycle, remembers who was granted in an ID FIFO and routes in-order responses back.
module bus_host_arbiter #(
    parameter int NrHosts        = 3,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter int RoundRobin     = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrHosts-1:0]             host_req_i,
    output logic [NrHosts-1:0]             host_gnt_o,
    input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]             host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]           host_rdata_o,
    output logic [NrHosts-1:0]             host_err_o,
    output logic                           device_req_o,
    input  logic                           device_gnt_i,
    output logic [AddrWidth-1:0]           device_addr_o,
    output logic                           device_we_o,
    output logic [DataWidth/8-1:0]         device_be_o,
    output logic [DataWidth-1:0]           device_wdata_o,
    input  logic                           device_rvalid_i,
    input  logic [DataWidth-1:0]           device_rdata_i,
    input  logic                           device_err_i,
    output logic                           busy_o,
    output logic                           protocol_err_o
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam int BeW   = DataWidth / 8;

    logic [HostW-1:0] id_fifo_q [MaxOutstanding];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [HostW-1:0] rr_ptr_q, lock_host_q;
    logic             lock_q;
    logic             protocol_err_q;

    logic [HostW-1:0] winner;
    logic             found;
    int               idx;
    logic             eligible;
    logic             accept;
    logic             pop;
    logic [HostW-1:0] head;

    // A stalled handshake pins the winner so the request presented to the device stays stable.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (lock_q) begin
            winner = lock_host_q;
            found  = 1'b1;
        end else begin
            for (int k = 0; k < NrHosts; k++) begin
                idx = (RoundRobin != 0) ? int'(rr_ptr_q) + k : k;
                if (idx >= NrHosts) begin
                    idx = idx - NrHosts;
                end
                if (!found && host_req_i[idx]) begin
                    winner = HostW'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    // No pop bypass: a response arriving this cycle does not free a slot for this cycle's grant.
    assign eligible     = (count_q < CntW'(MaxOutstanding));
    assign device_req_o = ~rst_i & eligible & host_req_i[winner];
    assign accept       = device_req_o & device_gnt_i;
    assign pop          = ~rst_i & device_rvalid_i & (count_q != '0);
    assign head         = id_fifo_q[rd_ptr_q];

    always_comb begin
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (device_req_o) begin
            device_addr_o  = host_addr_i[int'(winner)*AddrWidth +: AddrWidth];
            device_we_o    = host_we_i[winner];
            device_be_o    = host_be_i[int'(winner)*BeW +: BeW];
            device_wdata_o = host_wdata_i[int'(winner)*DataWidth +: DataWidth];
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        if (accept) begin
            host_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
        end
    end

    assign host_err_o     = host_rvalid_o & {NrHosts{device_err_i}};
    assign host_rdata_o   = device_rdata_i;
    assign busy_o         = ~rst_i & (count_q != '0);
    assign protocol_err_o = ~rst_i & protocol_err_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_fifo_q[wr_ptr_q] <= winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            lock_host_q    <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
                rr_ptr_q <= (winner == HostW'(NrHosts - 1)) ? '0 : winner + HostW'(1);
                lock_q   <= 1'b0;
            end else if (device_req_o) begin
                lock_q      <= 1'b1;
                lock_host_q <= winner;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (device_rvalid_i && (count_q == '0)) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb/tb_bus_host_arbiter.sv - bench for bus_host_arbiter, fixed-priority and round-robin instances
module tb_bus_host_arbiter;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    we;
    logic [N*BW-1:0] be;
    logic [N*DW-1:0] wdata;
    logic            dgnt, drvalid, derr;
    logic [DW-1:0]   drdata;

    logic [N-1:0]  o_gnt [2];
    logic [N-1:0]  o_rv [2];
    logic [N-1:0]  o_err [2];
    logic [DW-1:0] o_rdata [2];
    logic          o_dreq [2];
    logic [AW-1:0] o_addr [2];
    logic          o_we [2];
    logic [BW-1:0] o_be [2];
    logic [DW-1:0] o_wdata [2];
    logic          o_busy [2];
    logic          o_perr [2];

    bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MAXO), .RoundRobin(0)) dut_fp (
        .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(o_gnt[0]), .host_addr_i(addr),
        .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(o_rv[0]),
        .host_rdata_o(o_rdata[0]), .host_err_o(o_err[0]), .device_req_o(o_dreq[0]),
        .device_gnt_i(dgnt), .device_addr_o(o_addr[0]), .device_we_o(o_we[0]), .device_be_o(o_be[0]),
        .device_wdata_o(o_wdata[0]), .device_rvalid_i(drvalid), .device_rdata_i(drdata),
        .device_err_i(derr), .busy_o(o_busy[0]), .protocol_err_o(o_perr[0]));

    bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MAXO), .RoundRobin(1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(o_gnt[1]), .host_addr_i(addr),
        .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(o_rv[1]),
        .host_rdata_o(o_rdata[1]), .host_err_o(o_err[1]), .device_req_o(o_dreq[1]),
        .device_gnt_i(dgnt), .device_addr_o(o_addr[1]), .device_we_o(o_we[1]), .device_be_o(o_be[1]),
        .device_wdata_o(o_wdata[1]), .device_rvalid_i(drvalid), .device_rdata_i(drdata),
        .device_err_i(derr), .busy_o(o_busy[1]), .protocol_err_o(o_perr[1]));

    int checks = 0;
    int errors = 0;

    // Reference model: queue of granted host indices plus round-robin/lock/error bookkeeping.
    int mq [2][$];
    int m_rr [2];
    int m_lock [2];
    int m_lh [2];
    int m_perr [2];

    logic [N-1:0]  s_gnt [2];
    logic [N-1:0]  s_rv [2];
    logic [N-1:0]  s_err [2];
    logic          s_dreq [2];
    logic [AW-1:0] s_addr [2];
    logic          s_perr [2];
    logic          s_busy [2];
    logic [DW-1:0] s_rdata [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int m);
        int w;
        w = -1;
        if (m_lock[m] != 0) begin
            w = m_lh[m];
        end else if (m == 1) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_rr[m] + k) % N]) w = (m_rr[m] + k) % N;
            end
        end else begin
            for (int h = N - 1; h >= 0; h--) begin
                if (req[h]) w = h;
            end
        end
        return w;
    endfunction

    task automatic cycle();
        int            win [2];
        bit            dreq [2];
        logic [N-1:0]  eg, erv;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd;
        string         p;
        #2;
        for (int m = 0; m < 2; m++) begin
            p = (m == 0) ? "fp" : "rr";
            win[m] = pick(m);
            dreq[m] = !rst && (mq[m].size() < MAXO) && (win[m] >= 0) && req[win[m]];
            eg = '0; ea = '0; ewe = 1'b0; ebe = '0; ewd = '0; erv = '0;
            if (dreq[m]) begin
                ea  = addr[win[m]*AW +: AW];
                ewe = we[win[m]];
                ebe = be[win[m]*BW +: BW];
                ewd = wdata[win[m]*DW +: DW];
                if (dgnt) eg[win[m]] = 1'b1;
            end
            if (!rst && drvalid && mq[m].size() > 0) erv[mq[m][0]] = 1'b1;
            check({p, "_gnt"}, o_gnt[m], eg);
            check({p, "_dreq"}, o_dreq[m], dreq[m]);
            check({p, "_addr"}, o_addr[m], ea);
            check({p, "_we"}, o_we[m], ewe);
            check({p, "_be"}, o_be[m], ebe);
            check({p, "_wdata"}, o_wdata[m], ewd);
            check({p, "_rvalid"}, o_rv[m], erv);
            check({p, "_err"}, o_err[m], derr ? erv : '0);
            check({p, "_rdata"}, o_rdata[m], drdata);
            check({p, "_busy"}, o_busy[m], !rst && mq[m].size() != 0);
            check({p, "_perr"}, o_perr[m], !rst && m_perr[m] != 0);
            s_gnt[m] = o_gnt[m]; s_rv[m] = o_rv[m]; s_err[m] = o_err[m]; s_dreq[m] = o_dreq[m];
            s_addr[m] = o_addr[m]; s_perr[m] = o_perr[m]; s_busy[m] = o_busy[m]; s_rdata[m] = o_rdata[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mq[m].delete();
                m_rr[m] = 0; m_lock[m] = 0; m_lh[m] = 0; m_perr[m] = 0;
            end else begin
                if (drvalid) begin
                    if (mq[m].size() > 0) void'(mq[m].pop_front());
                    else m_perr[m] = 1;
                end
                if (dreq[m] && dgnt) begin
                    mq[m].push_back(win[m]);
                    m_rr[m] = (win[m] + 1) % N;
                    m_lock[m] = 0;
                end else if (dreq[m]) begin
                    m_lock[m] = 1;
                    m_lh[m] = win[m];
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic g, input logic rv,
                         input logic [DW-1:0] rd, input logic e);
        req = r; dgnt = g; drvalid = rv; drdata = rd; derr = e;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b111, 1'b1, 1'b0, '0, 1'b0);
        for (int h = 0; h < N; h++) begin
            addr[h*AW +: AW]  = 32'hA000_0000 + 32'(h * 16);
            wdata[h*DW +: DW] = 32'h5000_0000 + 32'(h);
            be[h*BW +: BW]    = 4'(h + 1);
        end
        we = 3'b010;
        @(negedge clk);

        // reset held with every host requesting
        do_reset(2);
        drive(3'b000, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        check("rst_busy_after", s_busy[0], 1'b0);
        check("rst_dreq_after", s_dreq[0], 1'b0);

        // fixed priority fills the FIFO with host 0
        drive(3'b111, 1'b1, 1'b0, '0, 1'b0);
        cycle(); check("fp_gnt_c1", s_gnt[0], 3'b001); check("rr_gnt_c1", s_gnt[1], 3'b001);
        cycle(); check("fp_gnt_c2", s_gnt[0], 3'b001); check("rr_gnt_c2", s_gnt[1], 3'b010);
        cycle(); check("fp_gnt_full", s_gnt[0], 3'b000); check("fp_dreq_full", s_dreq[0], 1'b0);

        // round robin with one-cycle responses
        do_reset(1);
        drive(3'b111, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_seq", s_gnt[1], 3'b001 << (i % 3));
            drvalid = 1'b1;
        end

        // stalled handshake keeps host 1 locked while host 0 joins
        do_reset(1);
        drive(3'b010, 1'b0, 1'b0, '0, 1'b0);
        cycle(); check("lock_addr_c1", s_addr[0], 32'hA000_0010);
        req = 3'b011;
        cycle(); check("lock_addr_c2", s_addr[0], 32'hA000_0010);
        cycle(); check("lock_addr_c3", s_addr[0], 32'hA000_0010); check("lock_gnt_c3", s_gnt[0], 3'b000);
        dgnt = 1'b1;
        cycle(); check("lock_gnt_c4", s_gnt[0], 3'b010);
        req = 3'b001;
        cycle(); check("lock_gnt_c5", s_gnt[0], 3'b001);

        // response routing with error
        do_reset(1);
        drive(3'b100, 1'b1, 1'b0, '0, 1'b0); cycle();
        drive(3'b001, 1'b1, 1'b0, '0, 1'b0); cycle();
        drive(3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0); cycle();
        check("route_rv1", s_rv[0], 3'b100); check("route_rd1", s_rdata[0], 32'hDEAD_BEEF);
        drive(3'b000, 1'b0, 1'b1, 32'h1234_5678, 1'b1); cycle();
        check("route_rv2", s_rv[0], 3'b001); check("route_err2", s_err[0], 3'b001);

        // full, pop+push, drain, stray response
        do_reset(1);
        drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
        cycle(); cycle();
        cycle(); check("full_dreq", s_dreq[0], 1'b0);
        drvalid = 1'b1;
        cycle(); check("full_pop_nogrant", s_gnt[0], 3'b000);
        cycle(); check("pushpop_gnt", s_gnt[0], 3'b001); check("pushpop_rv", s_rv[0], 3'b001);
        drvalid = 1'b0;
        cycle(); check("refill_gnt", s_gnt[0], 3'b001);
        cycle(); check("refull_dreq", s_dreq[0], 1'b0);
        drive(3'b000, 1'b0, 1'b1, '0, 1'b0);
        cycle(); cycle();
        cycle(); check("stray_rv", s_rv[0], 3'b000); check("drained_busy", s_busy[0], 1'b0);
        drvalid = 1'b0;
        cycle(); check("perr_set", s_perr[0], 1'b1);
        cycle(); check("perr_sticky", s_perr[0], 1'b1);
        do_reset(1);
        cycle(); check("perr_cleared", s_perr[0], 1'b0);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            req     = 3'($urandom);
            dgnt    = ($urandom_range(0, 3) != 0);
            drvalid = ($urandom_range(0, 1) == 1);
            drdata  = $urandom;
            derr    = ($urandom_range(0, 3) == 0);
            we      = 3'($urandom);
            be      = 12'($urandom);
            for (int h = 0; h < N; h++) begin
                addr[h*AW +: AW]  = $urandom;
                wdata[h*DW +: DW] = $urandom;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
